// File: rtl/gate_sensor_decoder.sv
// Gate beam-sensor front end: synchronise, debounce, decode passage direction into car_in/car_out pulses.
// Optional aborted-passage counter on port abort_cnt is built only when GATE_ABORT_CNT_EN is defined.
module gate_sensor_decoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 65535,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sensor_outer,
    input  logic       sensor_inner,
    output logic       car_in,
    output logic       car_out,
    output logic       busy,
    output logic       fault
`ifdef GATE_ABORT_CNT_EN
    ,
    output logic [7:0] abort_cnt
`endif
);

    typedef enum logic [3:0] {
        IDLE, EN_A, EN_AB, EN_B, EX_B, EX_BA, EX_A, CLR_WAIT, FAULT
    } state_t;

    // Bit 1 carries the outer beam, bit 0 the inner beam throughout.
    logic [1:0]       sync1_r, sync2_r, deb_r, deb_nxt_s;
    logic [CNT_W-1:0] dcnt_r     [2];
    logic [CNT_W-1:0] dcnt_nxt_s [2];
    state_t           state_r, step_s, nxt_s;
    logic [CNT_W-1:0] dwell_r;
    logic             passage_s;

    // Sequence step for one debounced sample (o,i); every unlisted combination is an abort.
    function automatic state_t passage_step(input state_t st, input logic [1:0] oi);
        state_t r;
        r = IDLE;
        case (st)
            IDLE:  case (oi) 2'b10: r = EN_A;  2'b01: r = EX_B;  2'b11: r = CLR_WAIT; default: r = IDLE; endcase
            EN_A:  case (oi) 2'b10: r = EN_A;  2'b11: r = EN_AB; 2'b00: r = IDLE;     default: r = CLR_WAIT; endcase
            EN_AB: case (oi) 2'b11: r = EN_AB; 2'b01: r = EN_B;  2'b10: r = EN_A;     default: r = CLR_WAIT; endcase
            EN_B:  case (oi) 2'b01: r = EN_B;  2'b00: r = IDLE;  2'b11: r = EN_AB;    default: r = CLR_WAIT; endcase
            EX_B:  case (oi) 2'b01: r = EX_B;  2'b11: r = EX_BA; 2'b00: r = IDLE;     default: r = CLR_WAIT; endcase
            EX_BA: case (oi) 2'b11: r = EX_BA; 2'b10: r = EX_A;  2'b01: r = EX_B;     default: r = CLR_WAIT; endcase
            EX_A:  case (oi) 2'b10: r = EX_A;  2'b00: r = IDLE;  2'b11: r = EX_BA;    default: r = CLR_WAIT; endcase
            CLR_WAIT, FAULT: r = (oi == 2'b00) ? IDLE : st;
            default: r = IDLE;
        endcase
        return r;
    endfunction

    // Two-flop synchronisers for both raw beams.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 2'b00;
            sync2_r <= 2'b00;
        end else begin
            sync1_r <= {sensor_outer, sensor_inner};
            sync2_r <= sync1_r;
        end
    end

    // Debounce: level follows the synced value after DEBOUNCE_CYCLES consecutive mismatching cycles.
    always_comb begin
        deb_nxt_s = deb_r;
        for (int k = 0; k < 2; k++) begin
            dcnt_nxt_s[k] = '0;
            if (sync2_r[k] != deb_r[k]) begin
                if (dcnt_r[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_nxt_s[k]  = sync2_r[k];
                    dcnt_nxt_s[k] = '0;
                end else begin
                    dcnt_nxt_s[k] = dcnt_r[k] + CNT_W'(1);
                end
            end else begin
                dcnt_nxt_s[k] = '0;
            end
        end
    end

    // Debounced level and mismatch counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb_r     <= 2'b00;
            dcnt_r[0] <= '0;
            dcnt_r[1] <= '0;
        end else begin
            deb_r     <= deb_nxt_s;
            dcnt_r[0] <= dcnt_nxt_s[0];
            dcnt_r[1] <= dcnt_nxt_s[1];
        end
    end

    // The FSM reacts to the level the debouncer commits on this same edge, so a raw edge
    // reaches the state register 2 + DEBOUNCE_CYCLES cycles later.
    always_comb begin
        step_s    = passage_step(state_r, deb_nxt_s);
        passage_s = (state_r != IDLE) && (state_r != FAULT);
        if ((step_s == state_r) && passage_s && (dwell_r == CNT_W'(TIMEOUT_CYCLES - 1))) begin
            nxt_s = FAULT;
        end else begin
            nxt_s = step_s;
        end
    end

    // Passage FSM with dwell timer and registered pulse/status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            dwell_r <= '0;
            car_in  <= 1'b0;
            car_out <= 1'b0;
            busy    <= 1'b0;
            fault   <= 1'b0;
        end else begin
            state_r <= nxt_s;
            dwell_r <= ((nxt_s != state_r) || !passage_s) ? '0 : dwell_r + CNT_W'(1);
            car_in  <= (state_r == EN_B) && (nxt_s == IDLE);
            car_out <= (state_r == EX_A) && (nxt_s == IDLE);
            busy    <= (nxt_s != IDLE);
            fault   <= (nxt_s == FAULT);
        end
    end

`ifdef GATE_ABORT_CNT_EN
    logic [7:0] abort_r;
    logic       abort_ev_s;

    assign abort_ev_s = (nxt_s != state_r) && ((nxt_s == CLR_WAIT) || (nxt_s == FAULT));

    // Saturating count of entries into CLR_WAIT or FAULT; only reset clears it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            abort_r <= 8'd0;
        end else if (abort_ev_s && (abort_r != 8'd255)) begin
            abort_r <= abort_r + 8'd1;
        end else begin
            abort_r <= abort_r;
        end
    end

    assign abort_cnt = abort_r;
`endif

endmodule

// File: tb/tb_gate_sensor_decoder.sv
// Bench for gate_sensor_decoder: vector table, hand timing sequences and random stimulus
// checked every cycle against a passage-position reference model.
module tb_gate_sensor_decoder;
    localparam int DEB = 4;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sensor_outer = 1'b0;
    logic sensor_inner = 1'b0;
    logic car_in, car_out, busy, fault;
`ifdef GATE_ABORT_CNT_EN
    logic [7:0] abort_cnt;
`endif

    gate_sensor_decoder #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .sensor_outer(sensor_outer), .sensor_inner(sensor_inner),
        .car_in(car_in), .car_out(car_out), .busy(busy), .fault(fault)
`ifdef GATE_ABORT_CNT_EN
        , .abort_cnt(abort_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int in_cnt = 0;
    int out_cnt = 0;

    // Reference model: mode 0 idle, 1 in a passage (dir 0 entry / 1 exit, pos 1..3), 2 clear-wait, 3 fault.
    logic [1:0] m_s1, m_s2, m_deb;
    int m_mc [2];
    int m_mode, m_dir, m_pos, m_dwell, m_abort;
    logic m_in, m_out;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Sensor pattern at position idx of an entry (dir 0) or exit (dir 1) sequence; 0 and 4 are "both clear".
    function automatic logic [1:0] seq_at(input int dir, input int idx);
        case (idx)
            1: return (dir == 0) ? 2'b10 : 2'b01;
            2: return 2'b11;
            3: return (dir == 0) ? 2'b01 : 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    task automatic model_reset();
        m_s1 = 2'b00; m_s2 = 2'b00; m_deb = 2'b00; m_mc[0] = 0; m_mc[1] = 0;
        m_mode = 0; m_dir = 0; m_pos = 0; m_dwell = 0; m_abort = 0; m_in = 1'b0; m_out = 1'b0;
    endtask

    task automatic model_edge(input logic o, input logic i);
        logic [1:0] s, v;
        int nm, nd, np;
        s = m_s2; m_s2 = m_s1; m_s1 = {o, i};
        for (int k = 0; k < 2; k++) begin
            if (s[k] != m_deb[k]) begin
                m_mc[k]++;
                if (m_mc[k] == DEB) begin m_deb[k] = s[k]; m_mc[k] = 0; end
            end else m_mc[k] = 0;
        end
        v = m_deb; m_in = 1'b0; m_out = 1'b0;
        nm = m_mode; nd = m_dir; np = m_pos;
        if (m_mode == 0) begin
            if (v == 2'b10) begin nm = 1; nd = 0; np = 1; end
            else if (v == 2'b01) begin nm = 1; nd = 1; np = 1; end
            else if (v == 2'b11) nm = 2;
        end else if (m_mode == 1) begin
            if (v == seq_at(m_dir, m_pos)) ;
            else if (v == seq_at(m_dir, m_pos + 1)) begin
                if (m_pos == 3) begin
                    nm = 0;
                    if (m_dir == 0) m_in = 1'b1; else m_out = 1'b1;
                end else np = m_pos + 1;
            end else if (v == seq_at(m_dir, m_pos - 1)) begin
                if (m_pos == 1) nm = 0; else np = m_pos - 1;
            end else nm = 2;
        end else if (v == 2'b00) nm = 0;
        if (nm != 1) begin nd = 0; np = 0; end
        if ((nm != m_mode) || (nd != m_dir) || (np != m_pos)) begin
            m_dwell = 0;
            if ((nm == 2 || nm == 3) && m_abort < 255) m_abort++;
        end else if (m_mode == 1 || m_mode == 2) begin
            m_dwell++;
            if (m_dwell == TMO) begin
                nm = 3; nd = 0; np = 0; m_dwell = 0;
                if (m_abort < 255) m_abort++;
            end
        end
        m_mode = nm; m_dir = nd; m_pos = np;
    endtask

    // One clock: drive on the falling edge, advance the model on the rising edge, compare 1 time unit later.
    task automatic step(input logic o, input logic i);
        @(negedge clk);
        sensor_outer = o;
        sensor_inner = i;
        @(posedge clk);
        model_edge(o, i);
        #1;
        chk("model_outputs", int'({car_in, car_out, busy, fault}),
            int'({m_in, m_out, (m_mode != 0), (m_mode == 3)}));
`ifdef GATE_ABORT_CNT_EN
        chk("model_abort_cnt", int'(abort_cnt), m_abort);
`endif
        if (car_in) in_cnt++;
        if (car_out) out_cnt++;
    endtask

    task automatic hold(input logic o, input logic i, input int n);
        for (int c = 0; c < n; c++) step(o, i);
    endtask

    typedef struct {
        logic o; logic i; int cyc;
        logic busy; logic fault; int ins; int outs; int aborts;
    } vec_t;
    vec_t tbl [16];

    initial begin
        int n, base_in, base_ab;
        tbl[0]  = '{1'b1, 1'b0, 20,  1'b1, 1'b0, 0, 0, 0};
        tbl[1]  = '{1'b1, 1'b1, 20,  1'b1, 1'b0, 0, 0, 0};
        tbl[2]  = '{1'b0, 1'b1, 20,  1'b1, 1'b0, 0, 0, 0};
        tbl[3]  = '{1'b0, 1'b0, 20,  1'b0, 1'b0, 1, 0, 0};
        tbl[4]  = '{1'b0, 1'b1, 20,  1'b1, 1'b0, 1, 0, 0};
        tbl[5]  = '{1'b1, 1'b1, 20,  1'b1, 1'b0, 1, 0, 0};
        tbl[6]  = '{1'b1, 1'b0, 20,  1'b1, 1'b0, 1, 0, 0};
        tbl[7]  = '{1'b0, 1'b0, 20,  1'b0, 1'b0, 1, 1, 0};
        tbl[8]  = '{1'b1, 1'b0, 3,   1'b0, 1'b0, 1, 1, 0};
        tbl[9]  = '{1'b0, 1'b0, 20,  1'b0, 1'b0, 1, 1, 0};
        tbl[10] = '{1'b1, 1'b0, 20,  1'b1, 1'b0, 1, 1, 0};
        tbl[11] = '{1'b0, 1'b0, 20,  1'b0, 1'b0, 1, 1, 0};
        tbl[12] = '{1'b1, 1'b0, 200, 1'b1, 1'b1, 1, 1, 1};
        tbl[13] = '{1'b0, 1'b0, 20,  1'b0, 1'b0, 1, 1, 1};
        tbl[14] = '{1'b1, 1'b1, 20,  1'b1, 1'b0, 1, 1, 2};
        tbl[15] = '{1'b0, 1'b0, 20,  1'b0, 1'b0, 1, 1, 2};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_car_in", int'(car_in), 0);
        chk("reset_car_out", int'(car_out), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_fault", int'(fault), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < 16; r++) begin
            hold(tbl[r].o, tbl[r].i, tbl[r].cyc);
            chk($sformatf("vec%0d_busy", r), int'(busy), int'(tbl[r].busy));
            chk($sformatf("vec%0d_fault", r), int'(fault), int'(tbl[r].fault));
            chk($sformatf("vec%0d_car_in_count", r), in_cnt, tbl[r].ins);
            chk($sformatf("vec%0d_car_out_count", r), out_cnt, tbl[r].outs);
`ifdef GATE_ABORT_CNT_EN
            chk($sformatf("vec%0d_abort_cnt", r), int'(abort_cnt), tbl[r].aborts);
`endif
        end

        // Entry pulse timing: 6 cycles after the inner beam clears, one cycle wide.
        hold(1'b1, 1'b0, 20); hold(1'b1, 1'b1, 20); hold(1'b0, 1'b1, 20);
        n = 0;
        do begin step(1'b0, 1'b0); n++; end while (!car_in && n < 30);
        chk("car_in_latency", n, 6);
        step(1'b0, 1'b0);
        chk("car_in_width", int'(car_in), 0);
        hold(1'b0, 1'b0, 10);

        // Exit pulse timing mirrors entry.
        hold(1'b0, 1'b1, 20); hold(1'b1, 1'b1, 20); hold(1'b1, 1'b0, 20);
        n = 0;
        do begin step(1'b0, 1'b0); n++; end while (!car_out && n < 30);
        chk("car_out_latency", n, 6);
        step(1'b0, 1'b0);
        chk("car_out_width", int'(car_out), 0);
        hold(1'b0, 1'b0, 10);

        // Timeout: fault 2 + DEB + TMO cycles after the rise, clears 6 cycles after release.
        base_in = in_cnt + out_cnt;
`ifdef GATE_ABORT_CNT_EN
        base_ab = int'(abort_cnt);
`else
        base_ab = 0;
`endif
        n = 0;
        do begin step(1'b1, 1'b0); n++; end while (!fault && n < 300);
        chk("fault_latency", n, 106);
`ifdef GATE_ABORT_CNT_EN
        chk("fault_abort_inc", int'(abort_cnt), base_ab + 1);
`endif
        n = 0;
        do begin step(1'b0, 1'b0); n++; end while (fault && n < 30);
        chk("fault_clear_latency", n, 6);
        hold(1'b0, 1'b0, 10);
        chk("fault_no_pulse", in_cnt + out_cnt, base_in);

        // Random sensor activity, checked every cycle by the model.
        for (int s = 0; s < 250; s++) begin
            logic [1:0] v;
            int len;
            v = 2'($urandom_range(0, 3));
            len = ($urandom_range(0, 9) == 0) ? $urandom_range(90, 130) : $urandom_range(1, 12);
            hold(v[1], v[0], len);
        end
        hold(1'b0, 1'b0, 20);

        // Repeated ambiguous passages saturate the abort counter.
        for (int r = 0; r < 300; r++) begin
            hold(1'b1, 1'b1, 8);
            hold(1'b0, 1'b0, 8);
        end
`ifdef GATE_ABORT_CNT_EN
        chk("abort_saturation", int'(abort_cnt), 255);
`endif
        chk("ambiguous_idle", int'(busy), 0);

        // Reset in the middle of an entry drops the passage.
        hold(1'b1, 1'b0, 10); hold(1'b1, 1'b1, 10);
        chk("mid_reset_busy_before", int'(busy), 1);
        base_in = in_cnt;
        #2;
        reset = 1'b1;
        #1;
        chk("mid_reset_busy", int'(busy), 0);
        chk("mid_reset_fault", int'(fault), 0);
        chk("mid_reset_pulses", int'({car_in, car_out}), 0);
`ifdef GATE_ABORT_CNT_EN
        chk("mid_reset_abort_cnt", int'(abort_cnt), 0);
`endif
        sensor_outer = 1'b0;
        sensor_inner = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        hold(1'b0, 1'b0, 20);
        chk("mid_reset_no_car_in", in_cnt, base_in);
        chk("mid_reset_idle", int'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the bench always terminates.
    initial begin
        #2000000;
        errors++;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
